// File: rtl/d_latch_pkg.sv
// rtl/d_latch_pkg.sv - shared constants and helpers for the d_latch bank
package d_latch_pkg;

    // Width used when the top level is instantiated without overriding LATCH_WIDTH
    localparam int D_LATCH_DEFAULT_WIDTH = 4;

    // Widest bank the top level accepts
    localparam int D_LATCH_MAX_WIDTH = 64;

    // Value every latch bit takes while reset is applied during the transparent phase
    localparam logic [D_LATCH_MAX_WIDTH-1:0] D_LATCH_RST_VALUE = '0;

    // True when a requested bank width is within the supported range
    function automatic bit d_latch_width_ok(input int width);
        return (width >= 1) && (width <= D_LATCH_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/d_latch_bit.sv
// rtl/d_latch_bit.sv - single-bit level-sensitive latch cell with gate-synchronous reset
module d_latch_bit
    import d_latch_pkg::*;
(
    input  logic G,
    input  logic RST,
    input  logic D,
    output logic Q
);

    // Transparent while G is high (reset wins over data); holds its value while G is low
    always_latch begin
        if (G) begin
            if (RST) begin
                Q <= D_LATCH_RST_VALUE[0];
            end else begin
                Q <= D;
            end
        end
    end

endmodule

// File: rtl/d_latch.sv
// rtl/d_latch.sv - LATCH_WIDTH-bit transparent latch bank; D_LATCH_PARITY_EN adds the QPAR output
module d_latch
    import d_latch_pkg::*;
#(
    parameter int LATCH_WIDTH = D_LATCH_DEFAULT_WIDTH
) (
    input  logic                   G,
    input  logic                   RST,
    input  logic [LATCH_WIDTH-1:0] D,
`ifdef D_LATCH_PARITY_EN
    output logic [LATCH_WIDTH-1:0] Q,
    output logic                   QPAR
`else
    output logic [LATCH_WIDTH-1:0] Q
`endif
);

    // Refuse to elaborate a bank whose width is outside the supported range
    if (!d_latch_width_ok(LATCH_WIDTH)) begin : g_width_check
        $error("d_latch: LATCH_WIDTH %0d outside 1..%0d", LATCH_WIDTH, D_LATCH_MAX_WIDTH);
    end

    // Bits share gate and reset but are otherwise independent cells
    for (genvar i = 0; i < LATCH_WIDTH; i++) begin : g_bit
        d_latch_bit u_bit (
            .G   (G),
            .RST (RST),
            .D   (D[i]),
            .Q   (Q[i])
        );
    end

`ifdef D_LATCH_PARITY_EN
    // Even parity of the latched word, so it tracks Q in both phases and is 0 under reset
    assign QPAR = ^Q;
`endif

endmodule

// File: tb/tb_d_latch.sv
// tb/tb_d_latch.sv - self-checking bench for the d_latch bank (also exercises D_LATCH_PARITY_EN)
module tb_d_latch;

    localparam int W = 4;

    typedef struct {
        logic         g;
        logic         rst;
        logic [W-1:0] d;
        logic [W-1:0] q;
    } vec_t;

    logic         G;
    logic         RST;
    logic [W-1:0] D;
    logic [W-1:0] Q;
`ifdef D_LATCH_PARITY_EN
    logic         QPAR;
`endif

    int tests = 0;
    int fails = 0;

    d_latch #(.LATCH_WIDTH(W)) dut (
        .G   (G),
        .RST (RST),
        .D   (D),
`ifdef D_LATCH_PARITY_EN
        .Q   (Q),
        .QPAR(QPAR)
`else
        .Q   (Q)
`endif
    );

    initial begin
        G = 1'b0;
        forever #50 G = ~G;
    end

    task automatic wait_until(input time t);
        if ($time < t) #(t - $time);
    endtask

    task automatic check_q(input string name, input logic [W-1:0] exp);
        tests++;
        if (Q !== exp) begin
            fails++;
            $display("FAIL %s: Q=%0h expected %0h at t=%0t", name, Q, exp, $time);
        end
`ifdef D_LATCH_PARITY_EN
        tests++;
        if (QPAR !== (^exp)) begin
            fails++;
            $display("FAIL %s_par: QPAR=%0b expected %0b at t=%0t", name, QPAR, ^exp, $time);
        end
`endif
    endtask

    vec_t vecs[$];
    logic [W-1:0] held;
    logic [W-1:0] exp_q;

    initial begin
        D   = '0;
        RST = 1'b0;

        // D steps while G is low: Q only moves at the next rising G
        for (int k = 0; k < 8; k++) begin
            wait_until(25 + 100 * k);
            D = W'(k);
            if (k == 3) begin
                wait_until(340);
                check_q("opaque_hold", 4'd2);
                wait_until(351);
                check_q("opaque_rise", 4'd3);
            end
        end

        // D steps while G is high: Q follows immediately
        for (int k = 0; k < 8; k++) begin
            wait_until(875 + 100 * k);
            D = W'(8 + k);
            #1;
            if (k < 2) check_q($sformatf("transp_%0d", k), W'(8 + k));
        end

        // table of single-phase vectors
        vecs.push_back('{1'b1, 1'b0, 4'd3,  4'd3});
        vecs.push_back('{1'b0, 1'b0, 4'd12, 4'd3});
        vecs.push_back('{1'b1, 1'b0, 4'd12, 4'd12});
        vecs.push_back('{1'b1, 1'b1, 4'd9,  4'd0});
        vecs.push_back('{1'b0, 1'b0, 4'd5,  4'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd5,  4'd5});
        vecs.push_back('{1'b0, 1'b1, 4'd10, 4'd5});
        vecs.push_back('{1'b1, 1'b0, 4'd10, 4'd10});
        vecs.push_back('{1'b0, 1'b0, 4'd1,  4'd10});
        vecs.push_back('{1'b1, 1'b0, 4'd15, 4'd15});
        vecs.push_back('{1'b1, 1'b0, 4'd0,  4'd0});
        foreach (vecs[i]) begin
            if (vecs[i].g) @(posedge G);
            else           @(negedge G);
            #10;
            RST = vecs[i].rst;
            D   = vecs[i].d;
            #1;
            check_q($sformatf("vec%0d", i), vecs[i].q);
        end
        RST = 1'b0;

        // hold across the falling edge
        @(posedge G); #10; D = 4'd5;  #1; check_q("hold_open", 4'd5);
        @(negedge G); #10; D = 4'd10; #1; check_q("hold_closed", 4'd5);
        @(posedge G); #1;                 check_q("hold_reopen", 4'd10);

        // reset while transparent, then release while still transparent
        #10; D = 4'd15; RST = 1'b1; #1; check_q("rst_open", 4'd0);
        #10; RST = 1'b0;            #1; check_q("rst_release", 4'd15);

        // reset pulse entirely inside the opaque phase is ignored
        @(posedge G); #10; D = 4'd6; #1; check_q("pre_opaque_rst", 4'd6);
        @(negedge G); #10; RST = 1'b1; #1; check_q("opaque_rst_on", 4'd6);
        #10; RST = 1'b0; #1; check_q("opaque_rst_off", 4'd6);
        @(posedge G); #1; check_q("opaque_rst_after", 4'd6);

        // reset and gate falling together leaves Q at zero
        #10; D = 4'd9; RST = 1'b1; #1; check_q("rst_fall_pre", 4'd0);
        @(negedge G); RST = 1'b0; #1; check_q("rst_fall_hold", 4'd0);
        #10; D = 4'd3; #1; check_q("rst_fall_ignore", 4'd0);

        // D changing in the same step as G rises shows the new D
        @(posedge G); D = 4'd12; #1; check_q("rise_same_step", 4'd12);

        // parity of an odd-weight word
        #10; D = 4'b0111; #1; check_q("parity_odd", 4'd7);

        // randomized phases checked against a held-value model
        held = Q;
        for (int it = 0; it < 40; it++) begin
            @(G);
            for (int s = 0; s < 2; s++) begin
                #($urandom_range(2, 12));
                D   = W'($urandom_range(0, 15));
                RST = ($urandom_range(0, 3) == 0);
                if (G) begin
                    exp_q = RST ? '0 : D;
                    held  = exp_q;
                end else begin
                    exp_q = held;
                end
                #1;
                check_q($sformatf("rand%0d_%0d", it, s), exp_q);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
